block_lock_ctrl: RTL and testbench

Lock controller for the 66b block aligner in the receive datapath. It sequences the aligner: resets its header counters, waits for its pipeline to settle, and qualifies its `block_offset` stream until one offset is stable. It then freezes that offset for the downstream gearbox slicer and monitors header quality at the frozen offset. Sustained bad headers or a software request drop lock and restart the hunt.

---
 rtl/block_lock_ctrl.sv | 155 +++++++++++++++
 tb/tb_block_lock_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/block_lock_ctrl.sv
// Lock controller for the 66b block aligner: resets the aligner, lets it
// settle, hunts for a stable block offset, then freezes it and monitors
// header quality at that offset.
module block_lock_ctrl #(
  parameter int unsigned SETTLE      = 4,
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned BAD_HDR_MAX = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       buffer_dv,
  input  logic [6:0] block_offset_i,
  input  logic [1:0] hdr_i,
  input  logic       resync_i,
  output logic       aligner_rst_o,
  output logic [6:0] offset_o,
  output logic       locked_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam logic [7:0] SETTLE_W  = 8'(SETTLE);
  localparam logic [7:0] LOCK_W    = 8'(LOCK_CNT);
  localparam logic [7:0] WINDOW_W  = 8'(WINDOW);
  localparam logic [7:0] BAD_MAX_W = 8'(BAD_HDR_MAX);
  localparam logic [6:0] MAX_OFS   = 7'd65;

  typedef enum logic [1:0] {S_RST_ALN, S_SETTLE, S_HUNT, S_LOCKED} state_t;

  state_t     state, state_nxt;
  logic [7:0] settle_cnt, settle_nxt;
  logic [7:0] stable_cnt, stable_nxt;
  logic [6:0] cand, cand_nxt;
  logic [7:0] blk_cnt, blk_nxt_r;
  logic [7:0] bad_cnt, bad_nxt_r;
  logic [6:0] offset_nxt;
  logic       locked_nxt;
  logic [7:0] loss_cnt_nxt;

  logic       bad;
  logic       loss;
  logic [7:0] bad_next;
  logic [7:0] blk_next;
  logic [7:0] stable_inc;

  // State and output registers; aligner reset is registered from next-state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= S_RST_ALN;
      settle_cnt      <= '0;
      stable_cnt      <= '0;
      cand            <= '0;
      blk_cnt         <= '0;
      bad_cnt         <= '0;
      aligner_rst_o   <= 1'b1;
      offset_o        <= '0;
      locked_o        <= 1'b0;
      lock_loss_cnt_o <= '0;
    end else begin
      state           <= state_nxt;
      settle_cnt      <= settle_nxt;
      stable_cnt      <= stable_nxt;
      cand            <= cand_nxt;
      blk_cnt         <= blk_nxt_r;
      bad_cnt         <= bad_nxt_r;
      aligner_rst_o   <= (state_nxt == S_RST_ALN);
      offset_o        <= offset_nxt;
      locked_o        <= locked_nxt;
      lock_loss_cnt_o <= loss_cnt_nxt;
    end
  end

  // Next-state, counter and output computation
  always_comb begin
    state_nxt    = state;
    settle_nxt   = settle_cnt;
    stable_nxt   = stable_cnt;
    cand_nxt     = cand;
    blk_nxt_r    = blk_cnt;
    bad_nxt_r    = bad_cnt;
    offset_nxt   = offset_o;
    locked_nxt   = locked_o;
    loss_cnt_nxt = lock_loss_cnt_o;
    loss         = 1'b0;
    bad          = !((hdr_i == 2'b01) || (hdr_i == 2'b10));
    bad_next     = bad_cnt + {7'b0, bad};
    blk_next     = blk_cnt + 8'd1;
    stable_inc   = stable_cnt + 8'd1;

    case (state)
      S_RST_ALN: begin
        state_nxt  = S_SETTLE;
        settle_nxt = '0;
        stable_nxt = '0;
      end
      S_SETTLE: begin
        if (buffer_dv) begin
          if (settle_cnt + 8'd1 == SETTLE_W) begin
            state_nxt  = S_HUNT;
            settle_nxt = '0;
            stable_nxt = '0;
          end else begin
            settle_nxt = settle_cnt + 8'd1;
          end
        end
      end
      S_HUNT: begin
        if (buffer_dv) begin
          if (block_offset_i > MAX_OFS) begin
            stable_nxt = '0;
          end else if ((stable_cnt != 8'd0) && (block_offset_i == cand)) begin
            stable_nxt = stable_inc;
            if (stable_inc == LOCK_W) begin
              offset_nxt = cand;
              locked_nxt = 1'b1;
              state_nxt  = S_LOCKED;
              blk_nxt_r  = '0;
              bad_nxt_r  = '0;
            end
          end else begin
            cand_nxt   = block_offset_i;
            stable_nxt = 8'd1;
          end
        end
      end
      S_LOCKED: begin
        if (buffer_dv) begin
          if (bad_next == BAD_MAX_W) begin
            loss       = 1'b1;
            locked_nxt = 1'b0;
            state_nxt  = S_RST_ALN;
          end else if (blk_next == WINDOW_W) begin
            blk_nxt_r = '0;
            bad_nxt_r = '0;
          end else begin
            blk_nxt_r = blk_next;
            bad_nxt_r = bad_next;
          end
        end
      end
      default: state_nxt = S_RST_ALN;
    endcase

    // Resync overrides everything; merged with header loss so a coincident
    // event counts only once.
    if (resync_i) begin
      state_nxt  = S_RST_ALN;
      locked_nxt = 1'b0;
      if (state == S_LOCKED) loss = 1'b1;
    end

    if (loss && (lock_loss_cnt_o != 8'hFF)) loss_cnt_nxt = lock_loss_cnt_o + 8'd1;
  end

endmodule

// File: tb/tb_block_lock_ctrl.sv
// Directed bench for block_lock_ctrl with default parameters.
module tb_block_lock_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       buffer_dv;
  logic [6:0] block_offset_i;
  logic [1:0] hdr_i;
  logic       resync_i;
  logic       aligner_rst_o;
  logic [6:0] offset_o;
  logic       locked_o;
  logic [7:0] lock_loss_cnt_o;

  int checks = 0;
  int errors = 0;

  block_lock_ctrl #(.SETTLE(4), .LOCK_CNT(16), .WINDOW(64), .BAD_HDR_MAX(8)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .buffer_dv      (buffer_dv),
    .block_offset_i (block_offset_i),
    .hdr_i          (hdr_i),
    .resync_i       (resync_i),
    .aligner_rst_o  (aligner_rst_o),
    .offset_o       (offset_o),
    .locked_o       (locked_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      $error("%s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Advance one clock and land 1 ns after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One buffer_dv pulse carrying an offset and header
  task automatic pulse(input logic [6:0] ofs, input logic [1:0] hdr);
    buffer_dv      = 1'b1;
    block_offset_i = ofs;
    hdr_i          = hdr;
    tick();
    buffer_dv      = 1'b0;
  endtask

  task automatic pulses(input int unsigned n, input logic [6:0] ofs);
    for (int unsigned i = 0; i < n; i++) pulse(ofs, 2'b01);
  endtask

  // Seven bad headers interleaved with good ones (14 blocks)
  task automatic seven_bad();
    for (int unsigned i = 0; i < 7; i++) begin
      pulse(7'd0, (i % 2 == 0) ? 2'b00 : 2'b11);
      pulse(7'd0, 2'b10);
    end
  endtask

  initial begin
    rst_i = 1'b1; buffer_dv = 1'b0; block_offset_i = '0; hdr_i = 2'b01; resync_i = 1'b0;
    #12;
    chk("rst_aligner_rst", {7'b0, aligner_rst_o}, 8'd1);
    chk("rst_locked", {7'b0, locked_o}, 8'd0);
    chk("rst_offset", {1'b0, offset_o}, 8'd0);
    chk("rst_loss_cnt", lock_loss_cnt_o, 8'd0);
    rst_i = 1'b0;
    tick();
    chk("aln_rst_falls", {7'b0, aligner_rst_o}, 8'd0);
    tick();
    chk("aln_rst_stays_low", {7'b0, aligner_rst_o}, 8'd0);

    // Acquisition: lock on dv #20
    pulses(19, 7'd37);
    chk("acq_not_locked_19", {7'b0, locked_o}, 8'd0);
    pulse(7'd37, 2'b01);
    chk("acq_locked_20", {7'b0, locked_o}, 8'd1);
    chk("acq_offset", {1'b0, offset_o}, 8'd37);

    // Four windows with 7 bad headers each, last one on block 64
    for (int unsigned w = 0; w < 4; w++) begin
      for (int unsigned b = 1; b <= 64; b++)
        pulse(7'd37, (b <= 6) ? 2'b00 : (b == 64) ? 2'b11 : 2'b01);
      chk("window_lock_held", {7'b0, locked_o}, 8'd1);
      chk("window_loss_cnt", lock_loss_cnt_o, 8'd0);
    end

    // Loss of lock on the 8th bad header in a window
    seven_bad();
    chk("seven_bad_locked", {7'b0, locked_o}, 8'd1);
    pulse(7'd0, 2'b11);
    chk("loss_locked", {7'b0, locked_o}, 8'd0);
    chk("loss_cnt_1", lock_loss_cnt_o, 8'd1);
    chk("loss_aln_rst_hi", {7'b0, aligner_rst_o}, 8'd1);
    chk("loss_offset_held", {1'b0, offset_o}, 8'd37);
    tick();
    chk("loss_aln_rst_lo", {7'b0, aligner_rst_o}, 8'd0);

    // Rehunt: settle, then 50x10, 12x1, 50x16
    pulses(4, 7'd9);
    pulses(10, 7'd50);
    pulse(7'd12, 2'b01);
    pulses(15, 7'd50);
    chk("hunt_restart_not_locked", {7'b0, locked_o}, 8'd0);
    chk("hunt_offset_frozen", {1'b0, offset_o}, 8'd37);
    pulse(7'd50, 2'b01);
    chk("hunt_relocked", {7'b0, locked_o}, 8'd1);
    chk("hunt_offset", {1'b0, offset_o}, 8'd50);

    // Resync coincident with 8th bad header counts once
    seven_bad();
    resync_i = 1'b1;
    pulse(7'd0, 2'b00);
    resync_i = 1'b0;
    chk("resync_bad_locked", {7'b0, locked_o}, 8'd0);
    chk("resync_bad_cnt", lock_loss_cnt_o, 8'd2);
    chk("resync_bad_aln_rst", {7'b0, aligner_rst_o}, 8'd1);
    tick();
    chk("resync_bad_aln_lo", {7'b0, aligner_rst_o}, 8'd0);

    // Resync during HUNT: no count, hunt restarts
    pulses(4, 7'd33);
    pulses(5, 7'd33);
    resync_i = 1'b1;
    tick();
    resync_i = 1'b0;
    chk("resync_hunt_aln_rst", {7'b0, aligner_rst_o}, 8'd1);
    chk("resync_hunt_cnt", lock_loss_cnt_o, 8'd2);
    tick();
    chk("resync_hunt_aln_lo", {7'b0, aligner_rst_o}, 8'd0);
    pulses(4, 7'd33);
    pulses(10, 7'd33);
    pulse(7'd70, 2'b01);
    chk("ofs70_not_locked", {7'b0, locked_o}, 8'd0);
    pulses(15, 7'd33);
    chk("ofs70_restart_not_locked", {7'b0, locked_o}, 8'd0);
    pulse(7'd33, 2'b01);
    chk("ofs70_relocked", {7'b0, locked_o}, 8'd1);
    chk("ofs70_offset", {1'b0, offset_o}, 8'd33);

    // Asynchronous reset pulse mid-LOCKED
    #3;
    rst_i = 1'b1;
    #1;
    chk("async_locked", {7'b0, locked_o}, 8'd0);
    chk("async_offset", {1'b0, offset_o}, 8'd0);
    chk("async_loss_cnt", lock_loss_cnt_o, 8'd0);
    chk("async_aln_rst", {7'b0, aligner_rst_o}, 8'd1);
    rst_i = 1'b0;
    tick();
    chk("async_aln_rst_lo", {7'b0, aligner_rst_o}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
